// File: rtl/packet_disassembler.sv
// packet_disassembler: splits 256-word host packets from the USB FIFO into per-channel and command FIFO writes.
//   rxclk/reset        : clock, synchronous active-high reset
//   usb_fifodata/usb_empty/usb_rdreq : USB FIFO read side; data is valid the cycle after usb_rdreq
//   chan_have_space/cmd_have_space   : target FIFOs can accept a full payload
//   adctime            : free-running sample time, used only when LATE_DISCARD_EN is defined
//   chan_data/chan_wrreq, cmd_data/cmd_wrreq : payload writes, one cycle after the word is read
//   pkt_timestamp/pkt_burst : fields of the current packet
//   pkt_start/drop_pulse/err_pulse : one pulse per packet: forwarded, discarded or malformed
//   debugbus           : {usb_empty, usb_rdreq, state, err_pulse, drop_pulse, pkt_start}
// Build option LATE_DISCARD_EN: discard packets whose timestamp is already behind adctime.
module packet_disassembler #(
    parameter int NUM_CHAN   = 1,
    parameter int MAXPAYLOAD = 504
) (
    input  logic                rxclk,
    input  logic                reset,
    input  logic [15:0]         usb_fifodata,
    input  logic                usb_empty,
    output logic                usb_rdreq,
    input  logic [NUM_CHAN:0]   chan_have_space,
    input  logic                cmd_have_space,
    input  logic [31:0]         adctime,
    output logic [15:0]         chan_data,
    output logic [NUM_CHAN:0]   chan_wrreq,
    output logic [15:0]         cmd_data,
    output logic                cmd_wrreq,
    output logic [31:0]         pkt_timestamp,
    output logic [1:0]          pkt_burst,
    output logic                pkt_start,
    output logic                drop_pulse,
    output logic                err_pulse,
    output logic [7:0]          debugbus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR1    = 3'd1;
    localparam logic [2:0] HDR2    = 3'd2;
    localparam logic [2:0] TS_LO   = 3'd3;
    localparam logic [2:0] TS_HI   = 3'd4;
    localparam logic [2:0] PAYLOAD = 3'd5;
    localparam logic [2:0] DISCARD = 3'd6;

    logic [2:0]        r_state;
    logic              r_rd_d;
    logic [7:0]        r_wcnt;
    logic [8:0]        r_len;
    logic [NUM_CHAN:0] r_sel;
    logic              r_is_cmd;
    logic              w_last;
    logic              w_hdr_bad;
    logic              w_is_data;
    logic              w_is_cmd;
    logic              w_space;
    logic              w_wr;
    logic [NUM_CHAN:0] w_sel;

    // wcnt+rd_d words have been requested; stop once the in-flight word is word 255
    assign w_last    = r_rd_d && (r_wcnt == 8'hFF);
    assign usb_rdreq = ~usb_empty && ~w_last;
    assign w_hdr_bad = (|usb_fifodata[15:13]) || (usb_fifodata[8:0] > 9'(MAXPAYLOAD)) || usb_fifodata[0];
    assign w_sel     = (NUM_CHAN+1)'(1) << usb_fifodata[4:0];
    assign w_is_data = usb_fifodata[4:0] <= 5'(NUM_CHAN);
    assign w_is_cmd  = usb_fifodata[4:0] == 5'h1F;
    assign w_space   = w_is_cmd ? cmd_have_space : |(chan_have_space & w_sel);
    // payload word k = wcnt-4 carries bytes 2k and 2k+1
    assign w_wr      = {r_wcnt - 8'd4, 1'b0} < r_len;
    assign debugbus  = {usb_empty, usb_rdreq, r_state, err_pulse, drop_pulse, pkt_start};

`ifdef LATE_DISCARD_EN
    logic [31:0] w_ts;
    logic [31:0] w_diff;
    logic        w_late;
    assign w_ts   = {usb_fifodata, pkt_timestamp[15:0]};
    assign w_diff = w_ts - adctime;
    // all-ones timestamp means "send now"
    assign w_late = w_diff[31] && (w_ts != 32'hFFFF_FFFF);
`else
    logic w_late;
    logic w_unused_adctime;
    assign w_late           = 1'b0;
    assign w_unused_adctime = ^adctime;
`endif

    always_ff @(posedge rxclk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rd_d        <= 1'b0;
            r_wcnt        <= 8'd0;
            r_len         <= 9'd0;
            r_sel         <= '0;
            r_is_cmd      <= 1'b0;
            chan_data     <= 16'd0;
            chan_wrreq    <= '0;
            cmd_data      <= 16'd0;
            cmd_wrreq     <= 1'b0;
            pkt_timestamp <= 32'd0;
            pkt_burst     <= 2'd0;
            pkt_start     <= 1'b0;
            drop_pulse    <= 1'b0;
            err_pulse     <= 1'b0;
        end else begin
            r_rd_d     <= usb_rdreq;
            r_wcnt     <= r_wcnt + {7'd0, r_rd_d};
            chan_wrreq <= '0;
            cmd_wrreq  <= 1'b0;
            pkt_start  <= 1'b0;
            drop_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            case (r_state)
                IDLE: if (!usb_empty) r_state <= HDR1;
                HDR1: if (r_rd_d) begin
                    r_len     <= usb_fifodata[8:0];
                    err_pulse <= w_hdr_bad;
                    r_state   <= w_hdr_bad ? DISCARD : HDR2;
                end
                HDR2: if (r_rd_d) begin
                    pkt_burst  <= usb_fifodata[12:11];
                    r_sel      <= w_sel;
                    r_is_cmd   <= w_is_cmd;
                    err_pulse  <= !(w_is_data || w_is_cmd);
                    drop_pulse <= (w_is_data || w_is_cmd) && !w_space;
                    r_state    <= ((w_is_data || w_is_cmd) && w_space) ? TS_LO : DISCARD;
                end
                TS_LO: if (r_rd_d) begin
                    pkt_timestamp[15:0] <= usb_fifodata;
                    r_state             <= TS_HI;
                end
                TS_HI: if (r_rd_d) begin
                    pkt_timestamp[31:16] <= usb_fifodata;
                    pkt_start            <= !w_late;
                    drop_pulse           <= w_late;
                    r_state              <= w_late ? DISCARD : PAYLOAD;
                end
                PAYLOAD: if (r_rd_d) begin
                    if (w_wr && r_is_cmd) begin
                        cmd_data  <= usb_fifodata;
                        cmd_wrreq <= 1'b1;
                    end
                    if (w_wr && !r_is_cmd) begin
                        chan_data  <= usb_fifodata;
                        chan_wrreq <= r_sel;
                    end
                    if (w_last) r_state <= IDLE;
                end
                DISCARD: if (w_last) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_disassembler.sv
// tb_packet_disassembler: directed packets through a modelled USB FIFO, checking writes, pulses and read counts.
module tb_packet_disassembler;
    logic        rxclk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] usb_fifodata = 16'd0;
    logic        usb_empty = 1'b1;
    logic        usb_rdreq;
    logic [1:0]  chan_have_space = 2'b11;
    logic        cmd_have_space = 1'b1;
    logic [31:0] adctime = 32'd0;
    logic [15:0] chan_data;
    logic [1:0]  chan_wrreq;
    logic [15:0] cmd_data;
    logic        cmd_wrreq;
    logic [31:0] pkt_timestamp;
    logic [1:0]  pkt_burst;
    logic        pkt_start;
    logic        drop_pulse;
    logic        err_pulse;
    logic [7:0]  debugbus;

    logic [15:0] q[$];
    logic [15:0] exp_q[$];
    logic [15:0] got[$];
    int n_assert = 0, n_fail = 0;
    int n_rd = 0, n_w0 = 0, n_w1 = 0, n_cmd = 0, n_start = 0, n_err = 0, n_drop = 0, n_multi = 0;
    int cyc = 0;
    logic stall_en = 1'b0;

    packet_disassembler #(.NUM_CHAN(1), .MAXPAYLOAD(504)) dut (
        .rxclk(rxclk), .reset(reset), .usb_fifodata(usb_fifodata), .usb_empty(usb_empty),
        .usb_rdreq(usb_rdreq), .chan_have_space(chan_have_space), .cmd_have_space(cmd_have_space),
        .adctime(adctime), .chan_data(chan_data), .chan_wrreq(chan_wrreq), .cmd_data(cmd_data),
        .cmd_wrreq(cmd_wrreq), .pkt_timestamp(pkt_timestamp), .pkt_burst(pkt_burst),
        .pkt_start(pkt_start), .drop_pulse(drop_pulse), .err_pulse(err_pulse), .debugbus(debugbus)
    );

    always #5 rxclk = ~rxclk;

    always @(posedge rxclk) begin
        if (usb_rdreq) begin
            n_rd++;
            if (q.size() > 0) usb_fifodata <= q.pop_front();
        end
    end

    always @(negedge rxclk) begin
        cyc++;
        usb_empty = (q.size() == 0) || (stall_en && (cyc % 6 < 3));
        if (chan_wrreq[0]) begin n_w0++; got.push_back(chan_data); end
        if (chan_wrreq[1]) begin n_w1++; got.push_back(chan_data); end
        if (cmd_wrreq) begin n_cmd++; got.push_back(cmd_data); end
        if (int'(chan_wrreq[0]) + int'(chan_wrreq[1]) + int'(cmd_wrreq) > 1) n_multi++;
        if (pkt_start) n_start++;
        if (err_pulse) n_err++;
        if (drop_pulse) n_drop++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_rd = 0; n_w0 = 0; n_w1 = 0; n_cmd = 0; n_start = 0; n_err = 0; n_drop = 0; n_multi = 0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic send(input string tag, input logic [15:0] h1, input logic [15:0] h2,
                        input logic [31:0] ts, input logic [15:0] base, input int nexp,
                        input int e_w0, input int e_w1, input int e_cmd,
                        input int e_start, input int e_err, input int e_drop);
        int t = 0;
        int bad = 0;
        clr();
        q.push_back(h1);
        q.push_back(h2);
        q.push_back(ts[15:0]);
        q.push_back(ts[31:16]);
        for (int i = 0; i < 252; i++) q.push_back(base + 16'(i) + 16'd1);
        for (int i = 0; i < nexp; i++) exp_q.push_back(base + 16'(i) + 16'd1);
        while (q.size() != 0 && t < 4000) begin
            @(negedge rxclk);
            t++;
        end
        repeat (4) @(negedge rxclk);
        chk({tag, ".timeout"}, 32'(t < 4000), 32'd1);
        chk({tag, ".rdreq"}, n_rd, 256);
        chk({tag, ".w0"}, n_w0, e_w0);
        chk({tag, ".w1"}, n_w1, e_w1);
        chk({tag, ".cmd"}, n_cmd, e_cmd);
        chk({tag, ".start"}, n_start, e_start);
        chk({tag, ".err"}, n_err, e_err);
        chk({tag, ".drop"}, n_drop, e_drop);
        chk({tag, ".multi"}, n_multi, 0);
        if (got.size() != exp_q.size()) bad++;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) bad++;
        chk({tag, ".order"}, bad, 0);
        chk({tag, ".state"}, 32'(debugbus[4:2]), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge rxclk);
        chk("rst.chan_wrreq", 32'(chan_wrreq), 32'd0);
        chk("rst.debugbus", 32'(debugbus), 32'h80);
        reset = 1'b0;
        @(negedge rxclk);
        chk("rst.chan_data", 32'(chan_data), 32'd0);
        chk("rst.cmd_data", 32'(cmd_data), 32'd0);
        chk("rst.timestamp", pkt_timestamp, 32'd0);
        chk("rst.burst", 32'(pkt_burst), 32'd0);
        chk("rst.rdreq", 32'(usb_rdreq), 32'd0);

        send("nominal", 16'h01F8, 16'h1000, 32'h1234_5678, 16'h0000, 252, 252, 0, 0, 1, 0, 0);
        chk("nominal.timestamp", pkt_timestamp, 32'h1234_5678);
        chk("nominal.burst", 32'(pkt_burst), 32'd2);

        send("short", 16'h0008, 16'h0801, 32'hAABB_CCDD, 16'h0100, 4, 0, 4, 0, 1, 0, 0);
        chk("short.burst", 32'(pkt_burst), 32'd1);
        chk("short.timestamp", pkt_timestamp, 32'hAABB_CCDD);

        stall_en = 1'b1;
        send("stall", 16'h01F8, 16'h0000, 32'h0000_0042, 16'h0000, 252, 252, 0, 0, 1, 0, 0);
        stall_en = 1'b0;

        send("mbz", 16'hE1F8, 16'h0000, 32'h0, 16'h0200, 0, 0, 0, 0, 0, 1, 0);
        chk("mbz.burst", 32'(pkt_burst), 32'd0);
        send("badchan", 16'h01F8, 16'h0005, 32'h0, 16'h0300, 0, 0, 0, 0, 0, 1, 0);
        send("odd", 16'h0007, 16'h0000, 32'h0, 16'h0400, 0, 0, 0, 0, 0, 1, 0);
        send("toolong", 16'h01FA, 16'h0000, 32'h0, 16'h0500, 0, 0, 0, 0, 0, 1, 0);

        send("cmd", 16'h0010, 16'h001F, 32'h0000_0100, 16'h0600, 8, 0, 0, 8, 1, 0, 0);
        cmd_have_space = 1'b0;
        send("cmdfull", 16'h0010, 16'h001F, 32'h0000_0100, 16'h0700, 0, 0, 0, 0, 0, 0, 1);
        cmd_have_space = 1'b1;
        chan_have_space = 2'b10;
        send("full", 16'h01F8, 16'h0000, 32'h0000_0100, 16'h0800, 0, 0, 0, 0, 0, 0, 1);
        chan_have_space = 2'b11;
        send("zero", 16'h0000, 16'h0000, 32'h0000_0100, 16'h0900, 0, 0, 0, 0, 1, 0, 0);
        send("maxlen", 16'h01F8, 16'h0001, 32'h0000_0100, 16'h0A00, 252, 0, 252, 0, 1, 0, 0);

        adctime = 32'h0000_1000;
`ifdef LATE_DISCARD_EN
        send("late", 16'h0008, 16'h0000, 32'h0000_0F00, 16'h0B00, 0, 0, 0, 0, 0, 0, 1);
        send("ontime", 16'h0008, 16'h0000, 32'h0000_1100, 16'h0C00, 4, 4, 0, 0, 1, 0, 0);
        send("sendnow", 16'h0008, 16'h0000, 32'hFFFF_FFFF, 16'h0D00, 4, 4, 0, 0, 1, 0, 0);
        adctime = 32'hFFFF_FFF0;
        send("wrap", 16'h0008, 16'h0000, 32'h0000_0010, 16'h0E00, 4, 4, 0, 0, 1, 0, 0);
`else
        send("nolate", 16'h0008, 16'h0000, 32'h0000_0F00, 16'h0B00, 4, 4, 0, 0, 1, 0, 0);
`endif

        q.push_back(16'h01F8);
        q.push_back(16'h0000);
        q.push_back(16'h0000);
        q.push_back(16'h0000);
        for (int i = 0; i < 252; i++) q.push_back(16'(i));
        repeat (40) @(negedge rxclk);
        reset = 1'b1;
        q.delete();
        @(negedge rxclk);
        chk("midrst.state", 32'(debugbus[4:2]), 32'd0);
        chk("midrst.wrreq", 32'(chan_wrreq), 32'd0);
        reset = 1'b0;
        @(negedge rxclk);
        send("afterrst", 16'h0008, 16'h0801, 32'h0000_2000, 16'h0F00, 4, 0, 4, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
